// File: rtl/barret_pkg.sv
// Barrett reducer support: derives the reduction constants from the modulus.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package barret_pkg;

    localparam int unsigned BARRET_DEFAULT_Q = 2339;

    // Shift amount K = 2*QW, so that every operand below 2^K reduces with at most two corrections.
    function automatic int unsigned barret_k(input int unsigned qw);
        return 2 * qw;
    endfunction

    // M = floor(2^K / Q).
    function automatic longint unsigned barret_m(input int unsigned q, input int unsigned k);
        longint unsigned one;
        one = 64'd1;
        return (one << k) / 64'(q);
    endfunction

    // Bit width of a canonical residue in [0, Q).
    function automatic int unsigned barret_res_w(input int unsigned q);
        return $clog2(q);
    endfunction

endpackage

// File: rtl/barret_pipe_stage.sv
// Generic valid/ready register slice holding one DW-bit word.
// Latency: 1 cycle. Ports: in_vld/in_rdy/in_dat upstream, out_vld/out_rdy/out_dat downstream.
// Backpressure: loads when empty or draining this cycle; in_rdy is combinational from out_rdy.
module barret_pipe_stage
    import barret_pkg::*;
#(
    parameter int unsigned DW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_dat
);

    logic          vld_q, vld_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          load;

    always_comb begin
        in_rdy = !vld_q || out_rdy;
        load   = in_vld && in_rdy;
        vld_d  = vld_q;
        dat_d  = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/barret_reduce_pipe.sv
// Pipelined Barrett reducer: dout_r = din_a mod Q for odd Q, tag passed alongside; optional macro BARRET_RANGE_CHECK_EN.
// Latency: 3 register stages (qhat, raw remainder, corrected residue); 1 result/cycle.
// Backpressure: full valid/ready; out_ready ripples combinationally to in_ready, up to 3 operands held.
// Ports: in_valid/in_ready/din_a/in_tag in, out_valid/out_ready/dout_r/out_tag/out_err out.
module barret_reduce_pipe
    import barret_pkg::*;
#(
    parameter int unsigned Q  = BARRET_DEFAULT_Q,
    parameter int unsigned QW = barret_res_w(Q),
    parameter int unsigned IW = 2 * QW - 1,
    parameter int unsigned TW = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] din_a,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] dout_r,
    output logic [TW-1:0] out_tag,
    output logic          out_err
);

    localparam int unsigned      K    = barret_k(QW);
    localparam logic [K-1:0]     M_C  = K'(barret_m(Q, K));
    localparam logic [K-1:0]     Q_K  = K'(Q);
    localparam logic [QW+1:0]    Q1_R = (QW + 2)'(Q);
    localparam logic [QW+1:0]    Q2_R = (QW + 2)'(2 * Q);

    if (IW >= K || (Q % 2) == 0 || Q < 3) begin : g_bad_param
        $error("barret_reduce_pipe: Q must be odd and >= 3, and IW < 2*QW");
    end

    typedef struct packed {
        logic [IW-1:0] x;
        logic [IW-1:0] qhat;
        logic [TW-1:0] tag;
        logic          err;
    } s1_t;

    typedef struct packed {
        logic [QW+1:0] r;
        logic [TW-1:0] tag;
        logic          err;
    } s2_t;

    typedef struct packed {
        logic [QW-1:0] res;
        logic [TW-1:0] tag;
        logic          err;
    } s3_t;

    s1_t  s1_in, s1_out;
    s2_t  s2_in, s2_out;
    s3_t  s3_in, s3_out;
    logic s1_vld, s2_vld, s2_rdy, s3_rdy;
    logic range_err;

`ifdef BARRET_RANGE_CHECK_EN
    localparam logic [IW:0] Q_SQ = (IW + 1)'(64'(Q) * 64'(Q));
    assign range_err = ({1'b0, din_a} >= Q_SQ);
`else
    assign range_err = 1'b0;
`endif

    // S1 input: quotient estimate qhat = floor(x*M / 2^K), never more than 2 below the true quotient.
    always_comb begin
        s1_in      = '0;
        s1_in.x    = din_a;
        s1_in.qhat = IW'(((IW + K)'(din_a) * (IW + K)'(M_C)) >> K);
        s1_in.tag  = in_tag;
        s1_in.err  = range_err;
    end

    // S2 input: remainder is < 3Q, so modular arithmetic on the low QW+2 bits is exact.
    always_comb begin
        s2_in     = '0;
        s2_in.r   = (QW + 2)'(K'(s1_out.x) - K'(s1_out.qhat) * Q_K);
        s2_in.tag = s1_out.tag;
        s2_in.err = s1_out.err;
    end

    // S3 input: final correction by 0, Q or 2Q into [0, Q).
    always_comb begin
        s3_in     = '0;
        s3_in.tag = s2_out.tag;
        s3_in.err = s2_out.err;
        if (s2_out.r >= Q2_R) begin
            s3_in.res = QW'(s2_out.r - Q2_R);
        end else if (s2_out.r >= Q1_R) begin
            s3_in.res = QW'(s2_out.r - Q1_R);
        end else begin
            s3_in.res = QW'(s2_out.r);
        end
    end

    barret_pipe_stage #(.DW($bits(s1_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (s1_in),
        .out_vld (s1_vld),
        .out_rdy (s2_rdy),
        .out_dat (s1_out)
    );

    barret_pipe_stage #(.DW($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (s1_vld),
        .in_rdy  (s2_rdy),
        .in_dat  (s2_in),
        .out_vld (s2_vld),
        .out_rdy (s3_rdy),
        .out_dat (s2_out)
    );

    barret_pipe_stage #(.DW($bits(s3_t))) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (s2_vld),
        .in_rdy  (s3_rdy),
        .in_dat  (s3_in),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (s3_out)
    );

    assign dout_r  = s3_out.res;
    assign out_tag = s3_out.tag;
    assign out_err = s3_out.err;

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Self-checking bench for barret_reduce_pipe: x % Q reference model with an in-order scoreboard,
// literal expectations on boundary operands, backpressure, stall stability and mid-stream reset.
// Two extra instances (Q=3329, Q=12289) run a concurrent random sweep on their own reset.
module tb_barret_reduce_pipe;

    localparam int unsigned QA = 2339;
    localparam int unsigned QB = 3329;
    localparam int unsigned QC = 12289;
    localparam int          QW = 12;
    localparam int          IW = 23;
    localparam int          TW = 16;
`ifdef BARRET_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, alt_rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [IW-1:0] din_a;
    logic [TW-1:0] in_tag, out_tag;
    logic [QW-1:0] dout_r;

    barret_reduce_pipe #(.Q(QA), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .din_a(din_a), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .dout_r(dout_r), .out_tag(out_tag), .out_err(out_err)
    );

    logic          b_iv, b_ir, b_ov, b_err;
    logic [22:0]   b_x;
    logic [11:0]   b_r;
    logic [TW-1:0] b_tin, b_tout;
    barret_reduce_pipe #(.Q(QB), .TW(TW)) dut_b (
        .clk(clk), .rst_n(alt_rst_n),
        .in_valid(b_iv), .in_ready(b_ir), .din_a(b_x), .in_tag(b_tin),
        .out_valid(b_ov), .out_ready(1'b1), .dout_r(b_r), .out_tag(b_tout), .out_err(b_err)
    );

    logic          c_iv, c_ir, c_ov, c_err;
    logic [26:0]   c_x;
    logic [13:0]   c_r;
    logic [TW-1:0] c_tin, c_tout;
    barret_reduce_pipe #(.Q(QC), .TW(TW)) dut_c (
        .clk(clk), .rst_n(alt_rst_n),
        .in_valid(c_iv), .in_ready(c_ir), .din_a(c_x), .in_tag(c_tin),
        .out_valid(c_ov), .out_ready(1'b1), .dout_r(c_r), .out_tag(c_tout), .out_err(c_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input longint act, input longint exp);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit model_err(input longint x, input longint q);
        return RANGE_EN && (x >= q * q);
    endfunction

    typedef struct {
        longint exp_r;
        longint tag;
        bit     exp_err;
        bit     lit;
        longint lit_r;
        bit     lit_err;
    } ent_t;

    ent_t   sb[$], qb[$], qc[$];
    ent_t   pe, ae;
    bit     cur_lit = 1'b0;
    longint cur_lit_r = 0;
    bit     cur_lit_err = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            first_acc = -1, first_out = -1, last_out = -1, acc_cnt = 0, out_cnt = 0;
    bit            hold_chk = 1'b0;
    logic [QW-1:0] h_r;
    logic [TW-1:0] h_tag;
    logic          h_err;

    // Main compare process: stall stability, then output pop, then input push.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("stall_valid", out_valid, 1);
                check("stall_residue", dout_r, h_r);
                check("stall_tag", out_tag, h_tag);
                check("stall_err", out_err, h_err);
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    note_fail("unexpected_output", dout_r, -1);
                end else begin
                    pe = sb.pop_front();
                    check("residue", dout_r, pe.exp_r);
                    check("tag", out_tag, pe.tag);
                    check("err", out_err, pe.exp_err);
                    if (pe.lit) begin
                        check("lit_residue", dout_r, pe.lit_r);
                        check("lit_err", out_err, pe.lit_err);
                    end
                end
                out_cnt++;
                last_out = cyc;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{longint'(din_a) % longint'(QA), longint'(in_tag),
                               model_err(longint'(din_a), longint'(QA)),
                               cur_lit, cur_lit_r, cur_lit_err});
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
            end
            hold_chk = out_valid && !out_ready;
            h_r      = dout_r;
            h_tag    = out_tag;
            h_err    = out_err;
        end
    end

    // Compare process for the alternate-modulus instances (out_ready tied high).
    always @(negedge clk) begin
        if (alt_rst_n) begin
            if (b_ov) begin
                if (qb.size() == 0) note_fail("b_unexpected", b_r, -1);
                else begin
                    ae = qb.pop_front();
                    check("b_residue", b_r, ae.exp_r);
                    check("b_tag", b_tout, ae.tag);
                    check("b_err", b_err, ae.exp_err);
                end
            end
            if (c_ov) begin
                if (qc.size() == 0) note_fail("c_unexpected", c_r, -1);
                else begin
                    ae = qc.pop_front();
                    check("c_residue", c_r, ae.exp_r);
                    check("c_tag", c_tout, ae.tag);
                    check("c_err", c_err, ae.exp_err);
                end
            end
            if (b_iv && b_ir)
                qb.push_back('{longint'(b_x) % longint'(QB), longint'(b_tin),
                               model_err(longint'(b_x), longint'(QB)), 1'b0, 0, 1'b0});
            if (c_iv && c_ir)
                qc.push_back('{longint'(c_x) % longint'(QC), longint'(c_tin),
                               model_err(longint'(c_x), longint'(QC)), 1'b0, 0, 1'b0});
        end
    end

    bit rand_or = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    end

    // Present one operand and hold it until accepted (bounded).
    task automatic send(input longint x, input int tg);
        din_a    = IW'(x);
        in_tag   = TW'(tg);
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                cur_lit  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        cur_lit  = 1'b0;
        note_fail("send_timeout", x, -1);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) note_fail("drain_timeout", sb.size(), 0);
    endtask

    bit alt_done = 1'b0;
    initial begin
        int nb, nc;
        bit ab, ac;
        nb = 0; nc = 0;
        alt_rst_n = 1'b0;
        b_iv = 1'b0; c_iv = 1'b0; b_x = '0; c_x = '0; b_tin = '0; c_tin = '0;
        repeat (2) @(posedge clk);
        #1 alt_rst_n = 1'b1;
        while (nb < 10000 || nc < 10000) begin
            @(negedge clk);
            ab = b_iv && b_ir;
            ac = c_iv && c_ir;
            @(posedge clk);
            #1;
            if (ab) nb++;
            if (ac) nc++;
            if (!b_iv || ab) begin
                b_iv  = (nb < 10000) && ($urandom_range(0, 1) == 1);
                b_x   = 23'($urandom_range(0, 32'h7F_FFFF));
                b_tin = TW'(nb);
            end
            if (!c_iv || ac) begin
                c_iv  = (nc < 10000) && ($urandom_range(0, 1) == 1);
                c_x   = 27'($urandom_range(0, 32'h7FF_FFFF));
                c_tin = TW'(nc);
            end
        end
        b_iv = 1'b0;
        c_iv = 1'b0;
        repeat (10) @(posedge clk);
        alt_done = 1'b1;
    end

    longint bx[6]   = '{2339, 5470920, 8388607, 5470921, 0, 2338};
    longint br[6]   = '{0, 2338, 953, 0, 0, 2338};
    bit     berr[6] = '{1'b0, 1'b0, RANGE_EN, RANGE_EN, 1'b0, 1'b0};

    initial begin
        int a0;
        bit acc;
        in_valid = 1'b0; din_a = '0; in_tag = '0; out_ready = 1'b0; rst_n = 1'b0;

        // Reset state, held and just after release.
        repeat (3) @(posedge clk);
        #1 check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        check("rel_out_valid", out_valid, 0);
        check("rel_dout_r", dout_r, 0);
        check("rel_out_tag", out_tag, 0);
        check("rel_out_err", out_err, 0);
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Full-range sweep at 1/cycle. The accept cycle counts as cycle 0:
        // out_valid is expected in the third cycle after it.
        out_ready = 1'b1;
        for (int x = 0; x < 2339; x++) send(x, x);
        drain();
        check("latency", first_out - first_acc, 3);
        check("sweep_count", out_cnt, 2339);
        check("sweep_rate", last_out - first_out, 2338);

        // Boundary operands with hand-computed residues.
        for (int i = 0; i < 6; i++) begin
            cur_lit     = 1'b1;
            cur_lit_r   = br[i];
            cur_lit_err = berr[i];
            send(bx[i], 1000 + i);
        end
        drain();

        // Random valid/ready with unique tags.
        rand_or = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send(longint'($urandom_range(0, 32'h7F_FFFF)), 5000 + i);
        end
        rand_or = 1'b0;
        out_ready = 1'b1;
        drain();

        // Full backpressure: exactly 3 accepts, then ready follows out_ready in the same cycle.
        out_ready = 1'b0;
        din_a     = IW'(100);
        in_tag    = TW'(20000);
        in_valid  = 1'b1;
        a0 = acc_cnt;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                din_a  = din_a + 1'b1;
                in_tag = in_tag + 1'b1;
            end
        end
        check("bp_accepts", acc_cnt - a0, 3);
        check("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1 check("bp_in_ready_release", in_ready, 1);
        send(200, 20010);
        send(201, 20011);
        drain();

        // Reset with three operands in flight.
        out_ready = 1'b0;
        send(11, 30001);
        send(12, 30002);
        send(13, 30003);
        check("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_valid", out_valid, 0);
        check("mid_reset_dout", dout_r, 0);
        check("mid_reset_tag", out_tag, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_reset_idle", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(4680, 30010);
        drain();

        for (int n = 0; n < 50000 && !alt_done; n++) @(posedge clk);
        if (!alt_done) note_fail("alt_timeout", 0, 1);
        check("sb_empty", sb.size(), 0);
        check("qb_empty", qb.size(), 0);
        check("qc_empty", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
